// File: rtl/uart_alu_frame_ctrl.sv
// uart_alu_frame_ctrl
//   Frame controller between the UART RX/TX FIFOs and a DATA_W-wide ALU.
//   Receives A[NB], B[NB], OPCODE[1] (multi-byte fields LSB-first, NB = DATA_W/8),
//   loads the ALU operand registers, captures the result and returns it as NB bytes.
//   Optional feature macro: STATUS_BYTE_EN appends {seq[5:0], sign, zero} after the result.
// Ports
//   clk, reset       clock, synchronous active-high reset
//   i_rx_data/_empty RX FIFO head byte (first-word fall-through) and empty flag
//   o_rd             RX pop (combinational)
//   o_tx_data/o_wr   byte and push strobe to the TX FIFO (o_wr combinational)
//   i_tx_full        TX FIFO full
//   o_op_a/_b/_code  registered ALU operands and opcode
//   i_alu_result     combinational ALU result
//   o_busy           high while executing / transmitting
//   o_frame_err      one-cycle pulse when a frame is dropped
module uart_alu_frame_ctrl #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned OP_W        = 6,
    parameter int unsigned TIMEOUT_CYC = 1_000_000,
    parameter int unsigned TMO_BITS    = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_empty,
    output logic              o_rd,
    output logic [7:0]        o_tx_data,
    input  logic              i_tx_full,
    output logic              o_wr,
    output logic [DATA_W-1:0] o_op_a,
    output logic [DATA_W-1:0] o_op_b,
    output logic [OP_W-1:0]   o_op_code,
    input  logic [DATA_W-1:0] i_alu_result,
    output logic              o_busy,
    output logic              o_frame_err
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {
        ST_RX_A   = 3'd0,
        ST_RX_B   = 3'd1,
        ST_RX_OP  = 3'd2,
        ST_EXEC   = 3'd3,
        ST_CAPT   = 3'd4,
        ST_TX_RES = 3'd5,
        ST_ERR    = 3'd6
`ifdef STATUS_BYTE_EN
        ,
        ST_TX_STAT = 3'd7
`endif
    } state_e;

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [TMO_BITS-1:0] tmo_q;
    logic [DATA_W-1:0]   a_sh_q;
    logic [DATA_W-1:0]   b_sh_q;
    logic [OP_W-1:0]     op_sh_q;
    logic [DATA_W-1:0]   sh_q;
    logic [DATA_W-1:0]   op_a_q;
    logic [DATA_W-1:0]   op_b_q;
    logic [OP_W-1:0]     op_code_q;
    logic                busy_q;
    logic                frame_err_q;
`ifdef STATUS_BYTE_EN
    logic [5:0]          seq_q;
    logic                sign_q;
    logic                zero_q;
`endif

    logic       rx_phase_c;
    logic       rd_c;
    logic       wr_c;
    logic [7:0] tx_data_c;
    logic [7:0] op_hi_c;
    logic       op_bad_c;
    logic       last_c;
    logic       tmo_active_c;
    logic       tmo_hit_c;

    // FIFO handshakes and frame-level decode; strobes are masked while reset
    // is asserted so nothing is popped or pushed in the aborting cycle.
    always_comb begin
        rx_phase_c   = (state_q == ST_RX_A) || (state_q == ST_RX_B) || (state_q == ST_RX_OP);
        rd_c         = rx_phase_c && !i_rx_empty && !reset;
        wr_c         = 1'b0;
        tx_data_c    = sh_q[7:0];
        if (!reset && (state_q == ST_TX_RES)) begin
            wr_c = !i_tx_full;
        end
`ifdef STATUS_BYTE_EN
        if (state_q == ST_TX_STAT) begin
            wr_c      = !i_tx_full && !reset;
            tx_data_c = {seq_q, sign_q, zero_q};
        end
`endif
        // bits above the opcode field must be zero (shift yields 0 when OP_W = 8)
        op_hi_c      = i_rx_data >> OP_W;
        op_bad_c     = |op_hi_c;
        last_c       = (cnt_q == CNT_W'(NB - 1));
        tmo_active_c = ((state_q == ST_RX_A) && (cnt_q != '0)) ||
                       (state_q == ST_RX_B) || (state_q == ST_RX_OP);
        tmo_hit_c    = tmo_active_c && !rd_c && (tmo_q == TMO_BITS'(TIMEOUT_CYC - 1));
    end

    assign o_rd        = rd_c;
    assign o_wr        = wr_c;
    assign o_tx_data   = tx_data_c;
    assign o_op_a      = op_a_q;
    assign o_op_b      = op_b_q;
    assign o_op_code   = op_code_q;
    assign o_busy      = busy_q;
    assign o_frame_err = frame_err_q;

    // Frame FSM with all datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RX_A;
            cnt_q       <= '0;
            tmo_q       <= '0;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            op_sh_q     <= '0;
            sh_q        <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_code_q   <= '0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef STATUS_BYTE_EN
            seq_q       <= '0;
            sign_q      <= 1'b0;
            zero_q      <= 1'b0;
`endif
        end else begin
            frame_err_q <= 1'b0;

            // inter-byte timeout: a pop always restarts it, so pop beats timeout
            if (rd_c || !tmo_active_c || tmo_hit_c) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + TMO_BITS'(1);
            end

            case (state_q)
                ST_RX_A: begin
                    if (rd_c) begin
                        for (int unsigned i = 0; i < NB; i++) begin
                            if (cnt_q == CNT_W'(i)) a_sh_q[i*8 +: 8] <= i_rx_data;
                        end
                        if (last_c) begin
                            cnt_q   <= '0;
                            state_q <= ST_RX_B;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end else if (tmo_hit_c) begin
                        cnt_q       <= '0;
                        frame_err_q <= 1'b1;
                        state_q     <= ST_ERR;
                    end
                end

                ST_RX_B: begin
                    if (rd_c) begin
                        for (int unsigned i = 0; i < NB; i++) begin
                            if (cnt_q == CNT_W'(i)) b_sh_q[i*8 +: 8] <= i_rx_data;
                        end
                        if (last_c) begin
                            cnt_q   <= '0;
                            state_q <= ST_RX_OP;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end else if (tmo_hit_c) begin
                        cnt_q       <= '0;
                        frame_err_q <= 1'b1;
                        state_q     <= ST_ERR;
                    end
                end

                ST_RX_OP: begin
                    if (rd_c) begin
                        if (op_bad_c) begin
                            frame_err_q <= 1'b1;
                            state_q     <= ST_ERR;
                        end else begin
                            op_sh_q <= i_rx_data[OP_W-1:0];
                            busy_q  <= 1'b1;
                            state_q <= ST_EXEC;
                        end
                    end else if (tmo_hit_c) begin
                        cnt_q       <= '0;
                        frame_err_q <= 1'b1;
                        state_q     <= ST_ERR;
                    end
                end

                // only place the ALU-facing registers change
                ST_EXEC: begin
                    op_a_q    <= a_sh_q;
                    op_b_q    <= b_sh_q;
                    op_code_q <= op_sh_q;
                    state_q   <= ST_CAPT;
                end

                ST_CAPT: begin
                    sh_q    <= i_alu_result;
                    cnt_q   <= '0;
`ifdef STATUS_BYTE_EN
                    sign_q  <= i_alu_result[DATA_W-1];
                    zero_q  <= (i_alu_result == '0);
`endif
                    state_q <= ST_TX_RES;
                end

                ST_TX_RES: begin
                    if (wr_c) begin
                        sh_q <= sh_q >> 8;
                        if (last_c) begin
                            cnt_q   <= '0;
`ifdef STATUS_BYTE_EN
                            state_q <= ST_TX_STAT;
`else
                            busy_q  <= 1'b0;
                            state_q <= ST_RX_A;
`endif
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end

`ifdef STATUS_BYTE_EN
                ST_TX_STAT: begin
                    if (wr_c) begin
                        seq_q   <= seq_q + 6'd1;
                        busy_q  <= 1'b0;
                        state_q <= ST_RX_A;
                    end
                end
`endif

                ST_ERR: begin
                    cnt_q   <= '0;
                    state_q <= ST_RX_A;
                end

                default: begin
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= ST_RX_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_alu_frame_ctrl.sv
// Testbench for uart_alu_frame_ctrl: directed frames with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_uart_alu_frame_ctrl;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned OP_W   = 6;
    localparam int unsigned NB     = DATA_W / 8;
    localparam int unsigned TMO    = 50;
    localparam int P_RX   = 0;
    localparam int P_BUSY = 1;
    localparam int P_ERR  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        i_rx_data;
    logic              i_rx_empty;
    logic              o_rd;
    logic [7:0]        o_tx_data;
    logic              i_tx_full;
    logic              o_wr;
    logic [DATA_W-1:0] o_op_a;
    logic [DATA_W-1:0] o_op_b;
    logic [OP_W-1:0]   o_op_code;
    logic [DATA_W-1:0] alu_res;
    logic              o_busy;
    logic              o_frame_err;

    uart_alu_frame_ctrl #(
        .DATA_W(DATA_W), .OP_W(OP_W), .TIMEOUT_CYC(TMO), .TMO_BITS(6)
    ) dut (
        .clk(clk), .reset(reset),
        .i_rx_data(i_rx_data), .i_rx_empty(i_rx_empty), .o_rd(o_rd),
        .o_tx_data(o_tx_data), .i_tx_full(i_tx_full), .o_wr(o_wr),
        .o_op_a(o_op_a), .o_op_b(o_op_b), .o_op_code(o_op_code),
        .i_alu_result(alu_res), .o_busy(o_busy), .o_frame_err(o_frame_err)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] alu_f(input logic [OP_W-1:0] op,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        if (op == 6'h20) return a + b;
        if (op == 6'h22) return a - b;
        return a ^ b;
    endfunction

    always_comb alu_res = alu_f(o_op_code, o_op_a, o_op_b);

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // environment
    logic [7:0] rx_q[$];
    logic [7:0] tx_log[$];
    bit rx_gate = 0;
    bit force_full = 0;
    int starve_pct = 0;
    int full_pct = 0;
    int err_seen = 0;

    // model state
    int phase = P_RX;
    logic [7:0] fb[$];
    logic [7:0] tx_exp[$];
    int idle = 0;
    int wait_c = 0;
    int seq = 0;
    int op_lag = 0;
    int pop_cyc = 0;
    int lat_last = -1;
    bit first_wr_pending = 0;
    logic [DATA_W-1:0] exp_a = '0, exp_b = '0, pend_a = '0, pend_b = '0;
    logic [OP_W-1:0]   exp_c = '0, pend_c = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        phase = P_RX; fb.delete(); tx_exp.delete();
        idle = 0; wait_c = 0; seq = 0; op_lag = 0; first_wr_pending = 0;
        exp_a = '0; exp_b = '0; exp_c = '0;
    endtask

    task automatic finish_frame();
        logic [DATA_W-1:0] a, b, r;
        logic [7:0] op;
        for (int i = 0; i < NB; i++) begin
            a[i*8 +: 8] = fb[i];
            b[i*8 +: 8] = fb[NB + i];
        end
        op = fb[2*NB];
        fb.delete();
        idle = 0;
        if (op[7:OP_W] != 0) begin
            phase = P_ERR;
        end else begin
            r = alu_f(op[OP_W-1:0], a, b);
            for (int i = 0; i < NB; i++) tx_exp.push_back(r[i*8 +: 8]);
`ifdef STATUS_BYTE_EN
            tx_exp.push_back({6'(seq), r[DATA_W-1], r == '0});
`endif
            pend_a = a; pend_b = b; pend_c = op[OP_W-1:0];
            op_lag = 2;
            wait_c = 2;
            phase = P_BUSY;
            pop_cyc = cyc;
            first_wr_pending = 1;
        end
    endtask

    // one model step per cycle; compares every DUT output the model predicts
    task automatic model_step();
        bit exp_rd, exp_wr;
        logic [7:0] eb;
        if (op_lag > 0) begin
            op_lag--;
            if (op_lag == 0) begin exp_a = pend_a; exp_b = pend_b; exp_c = pend_c; end
        end
        chk("op_a", 64'(o_op_a), 64'(exp_a));
        chk("op_b", 64'(o_op_b), 64'(exp_b));
        chk("op_code", 64'(o_op_code), 64'(exp_c));
        chk("busy", 64'(o_busy), 64'(phase == P_BUSY));
        chk("frame_err", 64'(o_frame_err), 64'(phase == P_ERR));
        if (o_frame_err) err_seen++;
        exp_rd = (phase == P_RX) && !i_rx_empty;
        exp_wr = (phase == P_BUSY) && (wait_c == 0) && (tx_exp.size() > 0) && !i_tx_full;
        chk("rd", 64'(o_rd), 64'(exp_rd));
        chk("wr", 64'(o_wr), 64'(exp_wr));
        if (o_rd && !i_rx_empty && rx_q.size() > 0) void'(rx_q.pop_front());
        if (o_wr) tx_log.push_back(o_tx_data);
        if (exp_wr) begin
            eb = tx_exp.pop_front();
            if (o_wr) chk("tx_data", 64'(o_tx_data), 64'(eb));
            if (first_wr_pending) begin lat_last = cyc - pop_cyc; first_wr_pending = 0; end
        end
        case (phase)
            P_ERR: phase = P_RX;
            P_BUSY: begin
                if (wait_c > 0) wait_c--;
                else if (exp_wr && tx_exp.size() == 0) begin
                    phase = P_RX;
                    seq = (seq + 1) % 64;
                end
            end
            default: begin
                if (exp_rd) begin
                    fb.push_back(i_rx_data);
                    idle = 0;
                    if (fb.size() == 2*NB + 1) finish_frame();
                end else if (fb.size() > 0) begin
                    idle++;
                    if (idle == TMO) begin phase = P_ERR; fb.delete(); idle = 0; end
                end
            end
        endcase
    endtask

    // FIFO models: drive on the falling edge, evaluate 1 ns later
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            i_rx_empty = (rx_q.size() == 0) || rx_gate ||
                         (starve_pct > 0 && $urandom_range(99) < starve_pct);
            i_rx_data  = (!i_rx_empty) ? rx_q[0] : 8'($urandom);
            i_tx_full  = force_full || (full_pct > 0 && $urandom_range(99) < full_pct);
            #1;
            if (reset) model_reset();
            else model_step();
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push_frame(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                              input logic [7:0] op);
        for (int i = 0; i < NB; i++) rx_q.push_back(a[i*8 +: 8]);
        for (int i = 0; i < NB; i++) rx_q.push_back(b[i*8 +: 8]);
        rx_q.push_back(op);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (!(rx_q.size() == 0 && phase == P_RX && fb.size() == 0) && k < budget) begin
            tick(1); k++;
        end
        if (k >= budget) begin
            checks++; errors++;
            $display("FAIL wait_idle: no idle after %0d cycles (cycle %0d)", budget, cyc);
        end
        tick(2);
    endtask

    task automatic wait_rx_level(input int level, input int budget);
        int k = 0;
        while (rx_q.size() > level && k < budget) begin tick(1); k++; end
        if (k >= budget) begin
            checks++; errors++;
            $display("FAIL wait_rx: FIFO level %0d after %0d cycles", rx_q.size(), budget);
        end
    endtask

    task automatic chk_log(input string name, input logic [7:0] e[$]);
        chk({name, "_len"}, 64'(tx_log.size()), 64'(e.size()));
        for (int i = 0; i < e.size(); i++) begin
            if (i < tx_log.size()) chk(name, 64'(tx_log[i]), 64'(e[i]));
        end
        tx_log.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] e[$];
        int e0, r, r2, k;
        logic [7:0] op;
        reset = 1'b1;
        i_rx_empty = 1'b1; i_rx_data = '0; i_tx_full = 1'b0;
        tick(3);
        chk("rst_op_a", 64'(o_op_a), 64'h0);
        chk("rst_op_code", 64'(o_op_code), 64'h0);
        chk("rst_busy", 64'(o_busy), 64'h0);
        chk("rst_frame_err", 64'(o_frame_err), 64'h0);
        reset = 1'b0;
        tick(2);

        // 1: ADD
        push_frame(16'h1234, 16'h0001, 8'h20);
        wait_idle(200);
`ifdef STATUS_BYTE_EN
        e = '{8'h35, 8'h12, 8'h00};
`else
        e = '{8'h35, 8'h12};
`endif
        chk_log("t1_tx", e);
        chk("t1_op_a", 64'(o_op_a), 64'h1234);
        chk("t1_op_b", 64'(o_op_b), 64'h0001);
        chk("t1_latency", 64'(lat_last), 64'd3);

        // 2: SUB under TX backpressure
        force_full = 1;
        push_frame(16'h0000, 16'h0001, 8'h22);
        tick(20);
        chk("t2_no_wr_full", 64'(tx_log.size()), 64'd0);
        chk("t2_busy_stall", 64'(o_busy), 64'd1);
        force_full = 0;
        wait_idle(200);
`ifdef STATUS_BYTE_EN
        e = '{8'hFF, 8'hFF, 8'h06};
`else
        e = '{8'hFF, 8'hFF};
`endif
        chk_log("t2_tx", e);

        // 3: timeout mid-frame, then a normal frame
        e0 = err_seen;
        rx_q.push_back(8'h34); rx_q.push_back(8'h12); rx_q.push_back(8'h01);
        tick(TMO + 30);
        chk("t3_err_pulse", 64'(err_seen - e0), 64'd1);
        chk("t3_no_tx", 64'(tx_log.size()), 64'd0);
        push_frame(16'h1234, 16'h0001, 8'h20);
        wait_idle(200);
`ifdef STATUS_BYTE_EN
        e = '{8'h35, 8'h12, 8'h08};
`else
        e = '{8'h35, 8'h12};
`endif
        chk_log("t3_tx", e);

        // 4: illegal opcode
        e0 = err_seen;
        push_frame(16'h0001, 16'h0001, 8'hC0);
        wait_idle(200);
        chk("t4_err_pulse", 64'(err_seen - e0), 64'd1);
        chk("t4_no_tx", 64'(tx_log.size()), 64'd0);
        chk("t4_op_a_kept", 64'(o_op_a), 64'h1234);
        chk("t4_op_code_kept", 64'(o_op_code), 64'h20);

        // 5: two frames back-to-back
        push_frame(16'h0010, 16'h0005, 8'h22);
        push_frame(16'hFFFF, 16'h0001, 8'h20);
        wait_idle(300);
`ifdef STATUS_BYTE_EN
        e = '{8'h0B, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h11};
`else
        e = '{8'h0B, 8'h00, 8'h00, 8'h00};
`endif
        chk_log("t5_tx", e);

        // 6: reset mid-frame
        rx_q.push_back(8'h34); rx_q.push_back(8'h12); rx_q.push_back(8'h01);
        wait_rx_level(0, 100);
        tick(2);
        reset = 1'b1; rx_q.delete();
        tick(2);
        reset = 1'b0;
        tx_log.delete();
        push_frame(16'h0005, 16'h0003, 8'h22);
        wait_idle(200);
`ifdef STATUS_BYTE_EN
        e = '{8'h02, 8'h00, 8'h00};
`else
        e = '{8'h02, 8'h00};
`endif
        chk_log("t6_tx", e);
        chk("t6_op_a", 64'(o_op_a), 64'h0005);

        // randomized traffic
        starve_pct = 30;
        full_pct = 30;
        for (int it = 0; it < 250; it++) begin
            r = $urandom_range(99);
            if (r < 8) begin
                k = $urandom_range(4, 1);
                for (int j = 0; j < k; j++) rx_q.push_back(8'($urandom));
                wait_rx_level(0, 500);
                rx_gate = 1;
                tick(TMO + 20);
                rx_gate = 0;
            end else if (r < 11) begin
                wait_idle(2000);
                rx_q.push_back(8'($urandom)); rx_q.push_back(8'($urandom));
                tick(3);
                reset = 1'b1; rx_q.delete();
                tick(1);
                reset = 1'b0;
            end else begin
                r2 = $urandom_range(99);
                if (r2 < 40)      op = 8'h20;
                else if (r2 < 80) op = 8'h22;
                else if (r2 < 92) op = 8'($urandom_range(63));
                else              op = 8'($urandom_range(255, 64));
                push_frame(16'($urandom), 16'($urandom), op);
                wait_rx_level(5, 500);
            end
            tx_log.delete();
        end
        starve_pct = 0;
        full_pct = 0;
        wait_idle(2000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
